// File: rtl/addsub2comp_n.sv
// Multi-cycle signed add/subtract through a sign-magnitude datapath (MAG, CMP, EXEC stages).
// One operation takes five states; a start is accepted only in IDLE, and operands are captured once at that point.
module addsub2comp_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic         S,
  input  logic         op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] R,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MAG  = 3'd1;
  localparam logic [2:0] ST_CMP  = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [W-1:0] ONE_W  = W'(1);
  localparam logic [W:0]   ONE_W1 = (W+1)'(1);
  // 2^(W-1) at W+1 bits: the largest magnitude a negative result may carry
  localparam logic [W:0]   LIM    = (W+1)'(1) << (W-1);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         op_q, op_d;
  logic         sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0] ma_q, ma_d, mb_q, mb_d;
  logic         seq_q, seq_d, agt_q, agt_d, aeq_q, aeq_d;
  logic [W-1:0] r_q, r_d;
  logic         ovf_q, ovf_d;

  logic [W:0]   mag;
  logic [W:0]   neg_mag;
  logic         sgn;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    seq_d   = seq_q;
    agt_d   = agt_q;
    aeq_d   = aeq_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    mag     = '0;
    neg_mag = '0;
    sgn     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (S) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          state_d = ST_MAG;
        end
      end
      ST_MAG: begin
        sa_d    = a_q[W-1];
        sb_d    = b_q[W-1] ^ op_q;
        // -2^(W-1) negates to itself, which reads as 2^(W-1) unsigned
        ma_d    = a_q[W-1] ? (~a_q + ONE_W) : a_q;
        mb_d    = b_q[W-1] ? (~b_q + ONE_W) : b_q;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        seq_d   = (sa_q == sb_q);
        agt_d   = (ma_q > mb_q);
        aeq_d   = (ma_q == mb_q);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (seq_q) begin
          mag = {1'b0, ma_q} + {1'b0, mb_q};
          sgn = sa_q;
        end else if (aeq_q) begin
          mag = '0;
          sgn = 1'b0;
        end else if (agt_q) begin
          mag = {1'b0, ma_q} - {1'b0, mb_q};
          sgn = sa_q;
        end else begin
          mag = {1'b0, mb_q} - {1'b0, ma_q};
          sgn = sb_q;
        end
        if (mag == '0) begin
          sgn = 1'b0;
        end
        neg_mag = ~mag + ONE_W1;
        r_d     = sgn ? neg_mag[W-1:0] : mag[W-1:0];
        ovf_d   = sgn ? (mag > LIM) : (mag >= LIM);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      seq_q   <= 1'b0;
      agt_q   <= 1'b0;
      aeq_q   <= 1'b0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      seq_q   <= seq_d;
      agt_q   <= agt_d;
      aeq_q   <= aeq_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
    end
  end

  assign R    = r_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_addsub2comp_n.sv
// Scoreboard bench for addsub2comp_n: expected results are queued at start time and
// checked by an independent monitor whenever done is observed.
module tb_addsub2comp_n;
  localparam int W = 8;

  logic         clk;
  logic         RESET_N;
  logic         S;
  logic         op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] R;
  logic         ovf;
  logic         busy;
  logic         done;

  addsub2comp_n #(.W(W)) dut (
    .clk(clk), .RESET_N(RESET_N), .S(S), .op(op), .A(A), .B(B),
    .R(R), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         v;
    int           due;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  logic [W-1:0] last_r;
  logic         last_v;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the signed operand values
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    int av, bv, res;
    logic [31:0] rb;
    exp_t e;
    av  = int'($signed(a));
    bv  = int'($signed(b));
    res = o ? av - bv : av + bv;
    rb  = 32'(res);
    e.r = rb[W-1:0];
    e.v = (res < -(1 << (W-1))) || (res > (1 << (W-1)) - 1);
    e.due = pcyc + 4;
    last_r = e.r;
    last_v = e.v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("R", 32'(R), 32'(e.r));
        chk("ovf", 32'(ovf), 32'(e.v));
        chk("done_cycle", 32'(pcyc), 32'(e.due));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 12 cycles");
    end
  endtask

  // Called at a negedge with the DUT idle; scrambles inputs while busy
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    S = 1'b1; A = a; B = b; op = o;
    push_exp(a, b, o);
    @(negedge clk);
    S = 1'b0; A = W'($urandom); B = W'($urandom); op = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    RESET_N = 1'b0; S = 1'b0; op = 1'b0; A = '0; B = '0;
    last_r = '0; last_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    RESET_N = 1'b1;
    @(negedge clk);

    run_op(8'd100, 8'd27, 1'b0);
    chk("hold_R", 32'(R), 32'h7F);
    run_op(8'd100, 8'd28, 1'b0);
    run_op(8'h80, 8'h01, 1'b1);
    run_op(8'h00, 8'h80, 1'b1);
    run_op(8'hCE, 8'd20, 1'b0);
    run_op(8'd5, 8'd5, 1'b1);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h80, 8'h80, 1'b1);
    run_op(8'h7F, 8'h81, 1'b1);
    run_op(8'd0, 8'd0, 1'b1);
    run_op(8'd3, 8'd7, 1'b0);
    @(negedge clk);
    chk("hold_R_idle", 32'(R), 32'(last_r));
    chk("hold_ovf_idle", 32'(ovf), 32'(last_v));

    // S held high: a new start every 5 cycles; operand churn while busy is ignored
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin
        if (i < 20) begin
          S = 1'b1; A = 8'd1; B = 8'd1; op = 1'b0;
          push_exp(A, B, op);
        end else begin
          S = 1'b0;
        end
      end else begin
        S = 1'($urandom); A = W'($urandom); B = W'($urandom); op = 1'($urandom);
      end
    end
    S = 1'b0;
    wait_idle();
    @(negedge clk);

    // Reset while in CMP aborts the operation
    run_op(8'd100, 8'd27, 1'b0);
    S = 1'b1; A = 8'd10; B = 8'd20; op = 1'b0;
    push_exp(A, B, op);
    @(negedge clk);
    S = 1'b0;
    @(negedge clk);
    #1 RESET_N = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_R", 32'(R), 32'd0);
    run_op(8'hF0, 8'h05, 1'b1);

    for (int i = 0; i < 300; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
